accel_row_accumulator: RTL and testbench
========================================

Name: accel_row_accumulator

Overview:
- Sits directly downstream of the getAccl pair pipeline and upstream of the velocity-update adders.
- Consumes the per-pair acceleration stream in row-major order: body i fixed, j sweeping.
- Sums ax and ay over each row using two pipelined AddSub instances (latency AddTime) in a feedback ring, then reduces the ring to one total per row.
- Emits one (body, sum_ax, sum_ay) result per row; exerts backpressure during reduction.

Parameters:
- BODIES, 512, maximum body count.
- BODY_ADDR_WIDTH, $clog2(BODIES), body index width.
- DATA_WIDTH, 64, IEEE-754 double width.
- AddTime, 20, AddSub latency in cycles; ring depth L = AddTime.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high; also drives AddSub areset.
- flush  input  1  synchronous abort; discards the current row and ring contents.
- in_valid  input  1  term present.
- in_ready  output  1  block accepts a term this cycle.
- in_ax  input  DATA_WIDTH  pair x-acceleration term.
- in_ay  input  DATA_WIDTH  pair y-acceleration term.
- in_body  input  BODY_ADDR_WIDTH  row index i.
- in_last  input  1  final term of the row.
- out_valid  output  1  one-cycle result pulse.
- out_body  output  BODY_ADDR_WIDTH  row index of the result.
- out_ax  output  DATA_WIDTH  row sum of x-terms.
- out_ay  output  DATA_WIDTH  row sum of y-terms.

Behaviour:
- Reset values: in_ready=0 during rst, then 1 on the first clk after release; out_valid=0, out_body=0, out_ax=0, out_ay=0; state=ACCUM; tag shift register=0; hold=empty; inflight=0.
- A term is accepted when in_valid && in_ready.
- ACCUM state:
  - in_ready=1.
  - Each cycle the adders receive a = accepted term (or +0.0 if none accepted) and b = (tag_out ? adder q : +0.0).
  - Tag shift register, L deep: tag_in = accepted || tag_out. It tracks which ring slots hold a live partial; inflight = number of set tags.
  - Accepting with in_last=1 latches in_body into out_body and moves to DRAIN on the next cycle.
- DRAIN state:
  - in_ready=0; no new terms enter.
  - When tag_out=1 and hold is empty: capture q into hold; slot feeds +0.0, tag_in=0.
  - When tag_out=1 and hold is full: feed a=hold, b=q, tag_in=1, clear hold; inflight decrements by 1.
  - When tag_out=1, hold empty and inflight==1: q is the final sum. Register it to out_ax/out_ay with out_valid=1 for exactly one cycle, clear all tags, return to ACCUM.
  - X and Y paths run in lockstep under one shared tag/hold control.
- Latency: in_last acceptance to out_valid is at most L*(ceil(log2 L)+1)+2 cycles, i.e. 122 for L=20.
- A single-term row returns that term exactly.
- Summation order is ring/pairwise, not sequential. Results may differ from a sequential sum by rounding. -0.0 terms may produce +0.0.
- in_ready drops the cycle after in_last is accepted and rises the cycle after the out_valid pulse. Upstream must hold in_valid and data while in_ready=0.
- flush=1 (any state): next cycle tags cleared, hold empty, state=ACCUM, out_valid=0, no result emitted. flush wins over a simultaneous acceptance, which is dropped.
- rst mid-row or mid-drain: immediate clear to reset values; the partial row is lost and no spurious out_valid occurs.
- Rows need no minimum length. in_last on the very first accepted term is legal.

Optional Feature:
- Macro ACCUM_HALF_KICK_EN.
- Defined: adds input port half_step (1 bit), sampled on the final-sum cycle. When 1, each output's exponent field [62:52] is decremented by 1 (result x0.5, the leapfrog half-kick). Fields equal to 0 or 2047 (zero/denormal/inf/NaN) pass unchanged.
- Undefined: port absent; outputs are unscaled sums.

Test Plan:
- Row body 7, ax {1.0,2.0,3.0,4.0}, ay {-1.0,-2.0,-3.0,-4.0}, in_last on the 4th -> one out_valid, out_body=7, out_ax=0x4024000000000000 (10.0), out_ay=0xC024000000000000 (-10.0), within 122 cycles.
- Single-term row body 3, ax=5.0, ay=0.0 with in_last -> out_ax=5.0 exact, out_ay=+0.0; in_ready=0 from the cycle after acceptance until the cycle after out_valid.
- 512 terms of 1.0 with random in_valid gaps -> out_ax=out_ay=512.0 (0x4080000000000000), exactly one pulse.
- Two back-to-back rows (bodies 0,1) with in_valid held high through the stall -> sums match per row, no term lost or duplicated, results in order.
- rst asserted mid-DRAIN, then a row of {2.0,2.0} -> no out_valid from the aborted row, next out_ax=4.0; repeat using flush with the same result.
- ACCUM_HALF_KICK_EN: sum 8.0 with half_step=1 -> out_ax=4.0; sum 0.0 -> 0.0; half_step=0 -> 8.0.

Source files
------------

// File: rtl/accel_row_accumulator.sv
// Row accumulator: ring-reduces per-pair (ax, ay) terms into one sum per body.
// Optional ACCUM_HALF_KICK_EN adds half_step to halve the emitted sums.
module accel_row_accumulator #(
   parameter int BODIES          = 512,
   parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
   parameter int DATA_WIDTH      = 64,
   parameter int AddTime         = 20
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_WIDTH-1:0]      in_ax,
   input  logic [DATA_WIDTH-1:0]      in_ay,
   input  logic [BODY_ADDR_WIDTH-1:0] in_body,
   input  logic                       in_last,
   output logic                       out_valid,
   output logic [BODY_ADDR_WIDTH-1:0] out_body,
   output logic [DATA_WIDTH-1:0]      out_ax,
   output logic [DATA_WIDTH-1:0]      out_ay
`ifdef ACCUM_HALF_KICK_EN
   ,
   input  logic                       half_step
`endif
);

   localparam int CW = $clog2(AddTime + 1);

   typedef enum logic {ACCUM, DRAIN} state_t;

   state_t                  state;
   logic [AddTime-1:0]      tags;
   logic [CW-1:0]           inflight;
   logic                    hold_v;
   logic [DATA_WIDTH-1:0]   hold_x, hold_y;
   logic [DATA_WIDTH-1:0]   px [AddTime];
   logic [DATA_WIDTH-1:0]   py [AddTime];
   logic [DATA_WIDTH-1:0]   a_x, a_y, b_x, b_y;
   logic [DATA_WIDTH-1:0]   qx, qy;
   logic                    tag_in, tag_out, accept;

   // Round-to-nearest-even double add; the pipe below supplies the latency.
   function automatic logic [63:0] fp_add(input logic [63:0] x,
                                          input logic [63:0] y);
      logic [63:0] p, q, r;
      logic [10:0] ep, eq, d;
      logic [55:0] mp, mq, al;
      logic [56:0] s;
      logic [12:0] e;
      logic [53:0] m;
      r = '0;
      if (x[62:0] >= y[62:0]) begin
         p = x;
         q = y;
      end else begin
         p = y;
         q = x;
      end
      if (p[62:52] == 11'h7ff) begin
         if (p[51:0] != '0 ||
             (q[62:52] == 11'h7ff && p[63] != q[63]))
            r = 64'h7ff8_0000_0000_0000;
         else
            r = p;
      end else begin
         ep = (p[62:52] == '0) ? 11'd1 : p[62:52];
         eq = (q[62:52] == '0) ? 11'd1 : q[62:52];
         mp = {p[62:52] != '0, p[51:0], 3'b000};
         mq = {q[62:52] != '0, q[51:0], 3'b000};
         d  = ep - eq;
         al = mq >> d;
         if ((al << d) != mq)
            al[0] = 1'b1;
         if (p[63] == q[63])
            s = {1'b0, mp} + {1'b0, al};
         else
            s = {1'b0, mp} - {1'b0, al};
         e = {2'b00, ep};
         if (s == '0) begin
            r = {p[63] & q[63], 63'd0};
         end else begin
            if (s[56]) begin
               s = {1'b0, s[56:2], s[1] | s[0]};
               e = e + 13'd1;
            end
            for (int i = 0; i < 55; i++) begin
               if (!s[55] && e > 13'd1) begin
                  s = s << 1;
                  e = e - 13'd1;
               end
            end
            m = {1'b0, s[55:3]} +
                {53'd0, s[2] & (s[1] | s[0] | s[3])};
            if (m[53]) begin
               m = m >> 1;
               e = e + 13'd1;
            end
            if (e >= 13'd2047)
               r = {p[63], 11'h7ff, 52'd0};
            else
               r = {p[63], m[52] ? e[10:0] : 11'd0, m[51:0]};
         end
      end
      return r;
   endfunction

`ifdef ACCUM_HALF_KICK_EN
   function automatic logic [63:0] kick(input logic [63:0] v,
                                        input logic       h);
      logic [63:0] r;
      r = v;
      if (h && v[62:52] != 11'd0 && v[62:52] != 11'h7ff)
         r[62:52] = v[62:52] - 11'd1;
      return r;
   endfunction
`endif

   assign qx      = px[AddTime-1];
   assign qy      = py[AddTime-1];
   assign tag_out = tags[AddTime-1];
   assign accept  = in_valid && in_ready && !flush && (state == ACCUM);

   always_comb begin
      a_x    = '0;
      a_y    = '0;
      b_x    = '0;
      b_y    = '0;
      tag_in = 1'b0;
      unique case (state)
         ACCUM: begin
            if (accept) begin
               a_x = in_ax;
               a_y = in_ay;
            end
            if (tag_out) begin
               b_x = qx;
               b_y = qy;
            end
            tag_in = accept || tag_out;
         end
         DRAIN: begin
            if (tag_out && hold_v) begin
               a_x    = hold_x;
               a_y    = hold_y;
               b_x    = qx;
               b_y    = qy;
               tag_in = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < AddTime; i++) begin
            px[i] <= '0;
            py[i] <= '0;
         end
      end else begin
         px[0] <= fp_add(a_x, b_x);
         py[0] <= fp_add(a_y, b_y);
         for (int i = 1; i < AddTime; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ACCUM;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_body  <= '0;
         out_ax    <= '0;
         out_ay    <= '0;
         tags      <= '0;
         inflight  <= '0;
         hold_v    <= 1'b0;
         hold_x    <= '0;
         hold_y    <= '0;
      end else begin
         out_valid <= 1'b0;
         if (flush) begin
            state    <= ACCUM;
            in_ready <= 1'b1;
            tags     <= '0;
            inflight <= '0;
            hold_v   <= 1'b0;
         end else begin
            tags     <= {tags[AddTime-2:0], tag_in};
            inflight <= inflight + CW'(tag_in) - CW'(tag_out);
            unique case (state)
               ACCUM: begin
                  in_ready <= 1'b1;
                  if (accept && in_last) begin
                     in_ready <= 1'b0;
                     out_body <= in_body;
                     state    <= DRAIN;
                  end
               end
               DRAIN: begin
                  if (tag_out) begin
                     if (hold_v) begin
                        hold_v <= 1'b0;
                     end else if (inflight == CW'(1)) begin
                        // Lone live partial: this is the row total.
`ifdef ACCUM_HALF_KICK_EN
                        out_ax <= kick(qx, half_step);
                        out_ay <= kick(qy, half_step);
`else
                        out_ax <= qx;
                        out_ay <= qy;
`endif
                        out_valid <= 1'b1;
                        tags      <= '0;
                        inflight  <= '0;
                        state     <= ACCUM;
                     end else begin
                        hold_v <= 1'b1;
                        hold_x <= qx;
                        hold_y <= qy;
                     end
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_accel_row_accumulator.sv
// Randomised bench for accel_row_accumulator against exact integer row sums.
// Half-kick checks are built only with ACCUM_HALF_KICK_EN.
module tb_accel_row_accumulator;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_last;
   logic        in_ready, out_valid;
   logic [8:0]  in_body, out_body;
   logic [63:0] in_ax, in_ay, out_ax, out_ay;
`ifdef ACCUM_HALF_KICK_EN
   logic        half_step;
`endif

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   real         tx[$], ty[$];
   int          r_body[$], r_cyc[$];
   logic [63:0] r_ax[$], r_ay[$];

   accel_row_accumulator dut (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_ax    (in_ax),
      .in_ay    (in_ay),
      .in_body  (in_body),
      .in_last  (in_last),
      .out_valid(out_valid),
      .out_body (out_body),
      .out_ax   (out_ax),
      .out_ay   (out_ay)
`ifdef ACCUM_HALF_KICK_EN
      ,
      .half_step(half_step)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (out_valid) begin
         r_body.push_back(int'(out_body));
         r_ax.push_back(out_ax);
         r_ay.push_back(out_ay);
         r_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   task automatic sums(output real sx, output real sy);
      sx = 0.0;
      sy = 0.0;
      foreach (tx[k]) begin
         sx += tx[k];
         sy += ty[k];
      end
   endtask

   task automatic rand_row(input int n);
      tx.delete();
      ty.delete();
      for (int k = 0; k < n; k++) begin
         tx.push_back(real'(int'($urandom_range(0, 2000)) - 1000));
         ty.push_back(real'(int'($urandom_range(0, 2000)) - 1000));
      end
   endtask

   task automatic send_row(input int body, input bit gaps,
                           output int acc);
      int w;
      acc = 0;
      for (int k = 0; k < tx.size(); k++) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clk);
         end
         in_valid = 1'b1;
         in_ax    = $realtobits(tx[k]);
         in_ay    = $realtobits(ty[k]);
         in_body  = 9'(body);
         in_last  = (k == tx.size() - 1);
         w = 0;
         while (!in_ready && w < 400) begin
            @(negedge clk);
            w++;
         end
         if (!in_ready)
            chk("stall_timeout", 64'(in_ready), 64'd1);
         @(negedge clk);
         acc = cyc;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic check_row(input string tag, input int body,
                            input real ex, input real ey,
                            input int acc);
      int w, b, c;
      logic [63:0] ax, ay;
      w = 0;
      while (r_body.size() == 0 && w < 300) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_pulse"}, 64'(r_body.size() != 0), 64'd1);
      if (r_body.size() != 0) begin
         b  = r_body.pop_front();
         ax = r_ax.pop_front();
         ay = r_ay.pop_front();
         c  = r_cyc.pop_front();
         chk({tag, "_body"}, 64'(b), 64'(body));
         chk({tag, "_ax"}, ax, $realtobits(ex));
         chk({tag, "_ay"}, ay, $realtobits(ey));
         chk({tag, "_lat"}, 64'((c - acc) > 0 && (c - acc) <= 122),
             64'd1);
      end
   endtask

   task automatic abort_test(input string tag, input bit use_rst);
      int acc;
      real ex, ey;
      tx = '{5.0, 6.0, 7.0};
      ty = '{1.0, 1.0, 1.0};
      send_row(9, 1'b0, acc);
      repeat (30) @(negedge clk);
      if (use_rst) rst = 1'b1;
      else flush = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      flush = 1'b0;
      repeat (150) @(negedge clk);
      chk({tag, "_quiet"}, 64'(r_body.size()), 64'd0);
      tx = '{2.0, 2.0};
      ty = '{0.5, -2.0};
      sums(ex, ey);
      send_row(2, 1'b0, acc);
      check_row({tag, "_next"}, 2, ex, ey, acc);
   endtask

   initial begin
      int acc, acc0, w;
      real ex, ey, ex0, ey0;
      rst      = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_body  = '0;
      in_ax    = '0;
      in_ay    = '0;
`ifdef ACCUM_HALF_KICK_EN
      half_step = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_ready", 64'(in_ready), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_body", 64'(out_body), 64'd0);
      chk("rst_ax", out_ax, 64'd0);
      chk("rst_ay", out_ay, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rel_ready", 64'(in_ready), 64'd1);

      tx = '{1.0, 2.0, 3.0, 4.0};
      ty = '{-1.0, -2.0, -3.0, -4.0};
      sums(ex, ey);
      send_row(7, 1'b0, acc);
      check_row("row7", 7, ex, ey, acc);
      chk("row7_ax_const", $realtobits(ex), 64'h4024000000000000);

      tx = '{5.0};
      ty = '{0.0};
      send_row(3, 1'b0, acc);
      w = 0;
      while (!out_valid && w < 200) begin
         chk("single_ready_low", 64'(in_ready), 64'd0);
         @(negedge clk);
         w++;
      end
      chk("single_ready_pulse", 64'(in_ready), 64'd0);
      @(negedge clk);
      chk("single_ready_up", 64'(in_ready), 64'd1);
      check_row("single", 3, 5.0, 0.0, acc);

      tx.delete();
      ty.delete();
      for (int k = 0; k < 512; k++) begin
         tx.push_back(1.0);
         ty.push_back(1.0);
      end
      send_row(100, 1'b1, acc);
      check_row("ones", 100, 512.0, 512.0, acc);
      repeat (40) @(negedge clk);
      chk("ones_once", 64'(r_body.size()), 64'd0);

      rand_row(7);
      sums(ex0, ey0);
      send_row(0, 1'b0, acc0);
      rand_row(13);
      sums(ex, ey);
      send_row(1, 1'b0, acc);
      check_row("b2b0", 0, ex0, ey0, acc0);
      check_row("b2b1", 1, ex, ey, acc);

      abort_test("rst", 1'b1);
      abort_test("flush", 1'b0);

      for (int r = 0; r < 8; r++) begin
         int body;
         body = int'($urandom_range(0, 511));
         rand_row(int'($urandom_range(1, 40)));
         sums(ex, ey);
         send_row(body, 1'b1, acc);
         check_row("rand", body, ex, ey, acc);
      end

`ifdef ACCUM_HALF_KICK_EN
      tx = '{3.0, 5.0};
      ty = '{1.0, -1.0};
      sums(ex, ey);
      half_step = 1'b1;
      send_row(4, 1'b0, acc);
      check_row("kick_on", 4, ex * 0.5, 0.0, acc);
      half_step = 1'b0;
      send_row(4, 1'b0, acc);
      check_row("kick_off", 4, ex, ey, acc);
`endif

      repeat (20) @(negedge clk);
      chk("no_stray", 64'(r_body.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d limit reached", cyc);
      $fatal(1, "watchdog");
   end

endmodule
